// File: rtl/sisc_exec_unit.sv
// SISC execution core: sequencing FSM, 32-bit ALU with {C,N,V,Z} flags, and write-back mux.
// Optional build macro SISC_ROTATE_EN enables ROTL/ROTR on function codes 8/9.
module sisc_exec_unit (
   input  logic        clk,
   input  logic        rst_f,
   input  logic [31:0] ir,
   input  logic [31:0] rsa,
   input  logic [31:0] rsb,
   input  logic [31:0] read_data,
   output logic        rf_we,
   output logic        wb_sel,
   output logic [31:0] write_data,
   output logic [1:0]  alu_op,
   output logic [31:0] alu_result,
   output logic [3:0]  stat,
   output logic        stat_en
);

   typedef enum logic [2:0] {
      START0, START1, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] alu_result_q, alu_result_d;

   logic [3:0]  opcode, mm;
   logic [15:0] imm;
   logic        is_alu, is_lod, is_hlt, mm_legal;
   logic        unused_fields;

   assign opcode        = ir[31:28];
   assign mm            = ir[27:24];
   assign imm           = ir[15:0];
   assign unused_fields = ^ir[23:16];
   assign is_alu        = (opcode == 4'h1) || (opcode == 4'h2);
   assign is_lod        = (opcode == 4'h3);
   assign is_hlt        = (opcode == 4'hF);
`ifdef SISC_ROTATE_EN
   assign mm_legal      = (mm <= 4'd9);
`else
   assign mm_legal      = (mm <= 4'd7);
`endif

   // ALU datapath and flags
   logic [31:0] src, res;
   logic [4:0]  sh;
   logic        c_f, v_f;

   always_comb begin
      src = (opcode == 4'h2) ? {16'h0000, imm} : rsb;
      sh  = src[4:0];
      res = rsa;
      c_f = 1'b0;
      v_f = 1'b0;
      case (mm)
         4'd0: begin
            {c_f, res} = {1'b0, rsa} + {1'b0, src};
            v_f = (rsa[31] == src[31]) && (res[31] != rsa[31]);
         end
         4'd1: begin
            res = rsa - src;
            c_f = (rsa >= src);
            v_f = (rsa[31] != src[31]) && (res[31] != rsa[31]);
         end
         4'd2: res = rsa & src;
         4'd3: res = rsa | src;
         4'd4: res = rsa ^ src;
         4'd5: res = ~rsa;
         // The extra bit past the word edge catches the last bit shifted out
         4'd6: {c_f, res} = {1'b0, rsa} << sh;
         4'd7: {res, c_f} = {rsa, 1'b0} >> sh;
`ifdef SISC_ROTATE_EN
         4'd8: begin
            res = (rsa << sh) | (rsa >> (6'd32 - {1'b0, sh}));
            c_f = (sh != 5'd0) && res[0];
         end
         4'd9: begin
            res = (rsa >> sh) | (rsa << (6'd32 - {1'b0, sh}));
            c_f = (sh != 5'd0) && res[31];
         end
`endif
         default: res = rsa;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      alu_result_d = alu_result_q;
      rf_we        = 1'b0;
      stat_en      = 1'b0;
      alu_op       = 2'b00;
      wb_sel       = 1'b0;
      stat         = 4'b0000;
      case (state_q)
         START0:    state_d = START1;
         START1:    state_d = FETCH;
         FETCH:     state_d = DECODE;
         DECODE:    state_d = EXECUTE;
         EXECUTE: begin
            state_d = is_hlt ? HALT : MEM;
            if (is_alu) begin
               alu_op       = {1'b1, opcode == 4'h2};
               stat         = {c_f, res[31], v_f, res == 32'h0};
               stat_en      = mm_legal;
               alu_result_d = mm_legal ? res : rsa;
            end
         end
         MEM:       state_d = WRITEBACK;
         WRITEBACK: begin
            state_d = FETCH;
            rf_we   = (is_alu && mm_legal) || is_lod;
            wb_sel  = is_lod;
         end
         HALT:      state_d = HALT;
         default:   state_d = START0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_f) begin
         state_q      <= START0;
         alu_result_q <= 32'h0;
      end else begin
         state_q      <= state_d;
         alu_result_q <= alu_result_d;
      end
   end

   assign alu_result = alu_result_q;
   assign write_data = wb_sel ? read_data : alu_result_q;

endmodule

// File: tb/tb_sisc_exec_unit.sv
// Self-checking bench for sisc_exec_unit: directed and random instructions against an arithmetic reference model.
module tb_sisc_exec_unit;
  logic        clk = 1'b0;
  logic        rst_f = 1'b1;
  logic [31:0] ir = '0, rsa = '0, rsb = '0, read_data = '0;
  logic        rf_we, wb_sel, stat_en;
  logic [31:0] write_data, alu_result;
  logic [1:0]  alu_op;
  logic [3:0]  stat;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] m_res = '0;

  sisc_exec_unit dut (
    .clk(clk), .rst_f(rst_f), .ir(ir), .rsa(rsa), .rsb(rsb), .read_data(read_data),
    .rf_we(rf_we), .wb_sel(wb_sel), .write_data(write_data), .alu_op(alu_op),
    .alu_result(alu_result), .stat(stat), .stat_en(stat_en)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".alu_result"}, alu_result, 32'h0);
    chk({tag, ".rf_we"},      32'(rf_we),   32'h0);
    chk({tag, ".stat_en"},    32'(stat_en), 32'h0);
    chk({tag, ".alu_op"},     32'(alu_op),  32'h0);
    chk({tag, ".wb_sel"},     32'(wb_sel),  32'h0);
    chk({tag, ".stat"},       32'(stat),    32'h0);
  endtask

  // Reference ALU: flags from plain integer arithmetic and bit-by-bit rotation
  function automatic void ref_alu(input logic [3:0] mm, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic [3:0] st, output bit legal);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint sr;
    logic [63:0] w;
    int n = int'(b[4:0]);
    bit c = 0, v = 0;
    legal = 1;
    r = a;
    case (mm)
      4'd0: begin
        w = {32'h0, a} + {32'h0, b}; r = w[31:0]; c = w[32];
        sr = sa + sb; v = (sr != longint'($signed(r)));
      end
      4'd1: begin
        r = a - b; c = (a >= b);
        sr = sa - sb; v = (sr != longint'($signed(r)));
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ~a;
      4'd6: begin r = a << n; c = (n != 0) && a[32 - n]; end
      4'd7: begin r = a >> n; c = (n != 0) && a[n - 1]; end
`ifdef SISC_ROTATE_EN
      4'd8: for (int k = 0; k < n; k++) begin c = r[31]; r = {r[30:0], r[31]}; end
      4'd9: for (int k = 0; k < n; k++) begin c = r[0];  r = {r[0], r[31:1]}; end
`endif
      default: legal = 0;
    endcase
    st = {c, r[31], v, r == 32'h0};
  endfunction

  // Entered in FETCH; leaves in FETCH of the next instruction (or START0 / HALT)
  task automatic run_instr(input logic [3:0] op, input logic [3:0] mm, input logic [31:0] a,
                           input logic [31:0] b, input logic [15:0] imm, input logic [31:0] rdat,
                           input bit rst_mid);
    logic [31:0] r, src;
    logic [3:0]  st;
    bit          legal, alu, lod;
    ir = {op, mm, 8'h5A, imm}; rsa = a; rsb = b; read_data = rdat;
    alu = (op == 4'h1) || (op == 4'h2);
    lod = (op == 4'h3);
    src = (op == 4'h2) ? {16'h0, imm} : b;
    ref_alu(mm, a, src, r, st, legal);
    for (int p = 0; p < 2; p++) begin
      chk("pre.rf_we",   32'(rf_we),   32'h0);
      chk("pre.stat_en", 32'(stat_en), 32'h0);
      chk("pre.alu_op",  32'(alu_op),  32'h0);
      tick;
    end
    chk("ex.alu_op",     32'(alu_op),  alu ? 32'({1'b1, op == 4'h2}) : 32'h0);
    chk("ex.stat_en",    32'(stat_en), 32'(alu && legal));
    chk("ex.alu_result", alu_result,   m_res);
    if (alu && legal) chk("ex.stat", 32'(stat), 32'(st));
    if (rst_mid) begin
      rst_f = 1'b1;
      tick;
      m_res = '0;
      chk_reset("midrst");
      rst_f = 1'b0;
      return;
    end
    tick;
    if (op == 4'hF) begin
      for (int k = 0; k < 10; k++) begin
        chk("hlt.rf_we",   32'(rf_we),   32'h0);
        chk("hlt.stat_en", 32'(stat_en), 32'h0);
        chk("hlt.alu_op",  32'(alu_op),  32'h0);
        tick;
      end
      return;
    end
    if (alu) m_res = legal ? r : a;
    chk("mem.alu_result", alu_result,   m_res);
    chk("mem.rf_we",      32'(rf_we),   32'h0);
    chk("mem.stat_en",    32'(stat_en), 32'h0);
    chk("mem.stat",       32'(stat),    32'h0);
    tick;
    chk("wb.rf_we",      32'(rf_we),   32'((alu && legal) || lod));
    chk("wb.wb_sel",     32'(wb_sel),  32'(lod));
    chk("wb.write_data", write_data,   lod ? rdat : m_res);
    chk("wb.stat_en",    32'(stat_en), 32'h0);
    tick;
  endtask

  initial begin
    logic [3:0] ops [7];
    ops = '{4'h1, 4'h2, 4'h1, 4'h2, 4'h3, 4'h0, 4'h6};
    tick; tick;
    chk_reset("rst");
    rst_f = 1'b0;
    tick;
    chk_reset("start1");
    tick;
    run_instr(4'h1, 4'd0, 32'd5, 32'd3, 16'h3000, 32'h0, 0);
    run_instr(4'h1, 4'd1, 32'd3, 32'd5, 16'h0000, 32'h0, 0);
    run_instr(4'h1, 4'd0, 32'h7FFFFFFF, 32'h1, 16'h0, 32'h0, 0);
    run_instr(4'h1, 4'd0, 32'hFFFFFFFF, 32'h1, 16'h0, 32'h0, 0);
    run_instr(4'h2, 4'd2, 32'h12345678, 32'hA5A5A5A5, 16'hFFFF, 32'h0, 0);
    run_instr(4'h3, 4'd0, 32'h1, 32'h2, 16'h0, 32'hDEADBEEF, 0);
    run_instr(4'h1, 4'd8, 32'h80000001, 32'h1, 16'h0, 32'h0, 0);
    run_instr(4'h1, 4'd9, 32'h80000001, 32'h1, 16'h0, 32'h0, 0);
    run_instr(4'h1, 4'd12, 32'hCAFEF00D, 32'h7, 16'h0, 32'h0, 0);
    run_instr(4'h1, 4'd6, 32'h80000001, 32'h0, 16'h0, 32'h0, 0);
    run_instr(4'h2, 4'd7, 32'h80000001, 32'h0, 16'h001F, 32'h0, 0);
    for (int i = 0; i < 30; i++)
      run_instr(ops[$urandom_range(0, 6)], 4'($urandom_range(0, 15)), $urandom, $urandom,
                16'($urandom), $urandom, 0);
    run_instr(4'hF, 4'd0, 32'h0, 32'h0, 16'h0, 32'h0, 0);
    rst_f = 1'b1;
    tick;
    m_res = '0;
    chk_reset("hltrst");
    rst_f = 1'b0;
    tick; tick;
    run_instr(4'h1, 4'd0, 32'h11111111, 32'h22222222, 16'h0, 32'h0, 1);
    tick; tick;
    run_instr(4'h1, 4'd4, 32'hF0F0F0F0, 32'hFF00FF00, 16'h0, 32'h0, 0);
    run_instr(4'h2, 4'd0, 32'hFFFF0001, 32'h0, 16'hFFFF, 32'h0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
